// File: rtl/btn_debounce_edge_if.sv
// ---------------------------------------------------------------------------
// btn_debounce_edge_if
//   Groups the button conditioner's data-path signals so the block and its
//   consumer can be connected as one bundle.
//
//   Signals:
//     btn_in       raw, unsynchronised button level       (master -> slave)
//     cnt_clr      synchronous clear of press_count       (master -> slave)
//     btn_level    debounced level                        (slave -> master)
//     rise_pulse   one-cycle pulse on accepted 0->1       (slave -> master)
//     fall_pulse   one-cycle pulse on accepted 1->0       (slave -> master)
//     busy         a candidate change is being qualified  (slave -> master)
//     press_count  accepted rises, modulo 2^CNT_W         (slave -> master)
//
//   Modports: master = the side that drives the button and the clear;
//             slave  = the debouncer itself.
// ---------------------------------------------------------------------------
interface btn_debounce_edge_if #(
    parameter int CNT_W = 8
);
    logic             btn_in;
    logic             cnt_clr;
    logic             btn_level;
    logic             rise_pulse;
    logic             fall_pulse;
    logic             busy;
    logic [CNT_W-1:0] press_count;

    modport master (
        output btn_in,
        output cnt_clr,
        input  btn_level,
        input  rise_pulse,
        input  fall_pulse,
        input  busy,
        input  press_count
    );

    modport slave (
        input  btn_in,
        input  cnt_clr,
        output btn_level,
        output rise_pulse,
        output fall_pulse,
        output busy,
        output press_count
    );
endinterface

// File: rtl/btn_debounce_edge.sv
// ---------------------------------------------------------------------------
// btn_debounce_edge
//   Conditions one raw asynchronous push-button input: a flop synchroniser,
//   a counter-qualified debounce state machine, a clean registered level,
//   single-cycle rise/fall pulses and a wrapping press counter.
//
//   Ports:
//     clk    system clock, all state on the rising edge
//     reset  asynchronous assert, synchronous release, active low
//     bus    btn_debounce_edge_if.slave (btn_in, cnt_clr in;
//            btn_level, rise_pulse, fall_pulse, busy, press_count out)
//
//   Parameters:
//     SYNC_STAGES      synchroniser depth (>= 2)
//     DEBOUNCE_CYCLES  consecutive stable synchronised cycles to accept a change (>= 1)
//     CNT_W            width of press_count (must match the interface)
// ---------------------------------------------------------------------------
module btn_debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    btn_debounce_edge_if.slave   bus
);

    localparam int STAB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   btn_sync;

    state_t                 state_q, state_d;
    logic [STAB_W-1:0]      stab_cnt_q, stab_cnt_d;
    logic                   qual_rise, qual_fall;

    logic                   btn_level_q, btn_level_d;
    logic                   rise_pulse_q, rise_pulse_d;
    logic                   fall_pulse_q, fall_pulse_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       press_count_q, press_count_d;

    // Shift chain: stage 0 takes the raw pin, the last stage feeds the FSM.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.btn_in};
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    // State register (all flops of the block).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q        <= '0;
            state_q       <= S_LOW;
            stab_cnt_q    <= '0;
            btn_level_q   <= 1'b0;
            rise_pulse_q  <= 1'b0;
            fall_pulse_q  <= 1'b0;
            busy_q        <= 1'b0;
            press_count_q <= '0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            stab_cnt_q    <= stab_cnt_d;
            btn_level_q   <= btn_level_d;
            rise_pulse_q  <= rise_pulse_d;
            fall_pulse_q  <= fall_pulse_d;
            busy_q        <= busy_d;
            press_count_q <= press_count_d;
        end
    end

    // Next-state logic. A check state counts stable cycles; any reversion
    // of btn_sync during the check drops straight back to the old level.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        qual_rise  = 1'b0;
        qual_fall  = 1'b0;
        case (state_q)
            S_LOW: begin
                if (btn_sync) begin
                    state_d    = S_RISE_CHK;
                    stab_cnt_d = '0;
                end
            end
            S_RISE_CHK: begin
                if (!btn_sync) begin
                    state_d    = S_LOW;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = S_HIGH;
                    stab_cnt_d = '0;
                    qual_rise  = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!btn_sync) begin
                    state_d    = S_FALL_CHK;
                    stab_cnt_d = '0;
                end
            end
            S_FALL_CHK: begin
                if (btn_sync) begin
                    state_d    = S_HIGH;
                    stab_cnt_d = '0;
                end else if (stab_cnt_q == STAB_LAST) begin
                    state_d    = S_LOW;
                    stab_cnt_d = '0;
                    qual_fall  = 1'b1;
                end else begin
                    stab_cnt_d = stab_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = S_LOW;
                stab_cnt_d = '0;
            end
        endcase
    end

    // Output logic. Outputs are registered, so busy is derived from the
    // next state to line up exactly with the check states.
    always_comb begin
        btn_level_d   = btn_level_q;
        rise_pulse_d  = qual_rise;
        fall_pulse_d  = qual_fall;
        busy_d        = (state_d == S_RISE_CHK) || (state_d == S_FALL_CHK);
        press_count_d = press_count_q;

        if (qual_rise) begin
            btn_level_d = 1'b1;
        end
        if (qual_fall) begin
            btn_level_d = 1'b0;
        end

        // A clear coinciding with an accepted rise still counts that rise.
        if (bus.cnt_clr) begin
            press_count_d = qual_rise ? CNT_W'(1) : '0;
        end else if (qual_rise) begin
            press_count_d = press_count_q + 1'b1;
        end
    end

    assign bus.btn_level   = btn_level_q;
    assign bus.rise_pulse  = rise_pulse_q;
    assign bus.fall_pulse  = fall_pulse_q;
    assign bus.busy        = busy_q;
    assign bus.press_count = press_count_q;

endmodule

// File: tb/tb_btn_debounce_edge.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_edge
//   Directed bench for btn_debounce_edge (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
//   CNT_W=8). Stimulus pushes the expected pulse (kind, edge, count, level)
//   into a queue; a monitor pops and compares whenever a pulse appears.
// ---------------------------------------------------------------------------
module tb_btn_debounce_edge;

    localparam int LAT = 6;  // SYNC_STAGES + DEBOUNCE_CYCLES

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        logic       is_rise;
        int         at_edge;
        logic [7:0] count;
        logic       level;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] exp_count;

    btn_debounce_edge_if #(.CNT_W(8)) bus ();

    btn_debounce_edge #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge n occurs at time 10n-5; the negedge after edge n is at time 10n.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Call only at a negedge; returns at the negedge following edge n.
    task automatic wait_edge(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_press(input logic clr_on_rise);
        int k;
        bus.btn_in = 1'b1;
        k = cyc + 1;
        exp_count = clr_on_rise ? 8'd1 : exp_count + 8'd1;
        exp_q.push_back('{1'b1, k + LAT, exp_count, 1'b1});
        $display("press   sampled edge %0d expect rise at %0d count %0d", k, k + LAT, exp_count);
        wait_edge(k + LAT - 1);
        if (clr_on_rise) bus.cnt_clr = 1'b1;
        wait_edge(k + LAT);
        bus.cnt_clr = 1'b0;
        wait_edge(k + LAT + 2);
    endtask

    task automatic do_release();
        int k;
        bus.btn_in = 1'b0;
        k = cyc + 1;
        exp_q.push_back('{1'b0, k + LAT, exp_count, 1'b0});
        $display("release sampled edge %0d expect fall at %0d count %0d", k, k + LAT, exp_count);
        wait_edge(k + LAT + 2);
    endtask

    // Monitor: compares every pulse against the head of the queue and
    // flags expected pulses that never arrived.
    always @(negedge clk) begin
        if (bus.rise_pulse && bus.fall_pulse) begin
            chk("pulse_exclusive", 1, 0);
        end else if (bus.rise_pulse || bus.fall_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse at edge %0d: got rise=%0b fall=%0b expected none",
                         cyc, bus.rise_pulse, bus.fall_pulse);
            end else begin
                mon_e = exp_q.pop_front();
                $display("pulse   edge %0d rise=%0b count=%0d level=%0b",
                         cyc, bus.rise_pulse, bus.press_count, bus.btn_level);
                chk("pulse_kind",  int'(bus.rise_pulse),  int'(mon_e.is_rise));
                chk("pulse_edge",  cyc,                   mon_e.at_edge);
                chk("pulse_count", int'(bus.press_count), int'(mon_e.count));
                chk("pulse_level", int'(bus.btn_level),   int'(mon_e.level));
            end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].at_edge) begin
            mon_e = exp_q.pop_front();
            chk("missed_pulse_edge", cyc, mon_e.at_edge);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        checks      = 0;
        failures    = 0;
        exp_count   = 8'd0;
        reset       = 1'b0;
        bus.btn_in  = 1'b0;
        bus.cnt_clr = 1'b0;

        // Reset state.
        wait_edge(2);
        chk("rst_level", int'(bus.btn_level),   0);
        chk("rst_rise",  int'(bus.rise_pulse),  0);
        chk("rst_fall",  int'(bus.fall_pulse),  0);
        chk("rst_busy",  int'(bus.busy),        0);
        chk("rst_count", int'(bus.press_count), 0);
        reset = 1'b1;

        // Clean press sampled at edge 10 -> rise at edge 16.
        wait_edge(9);
        bus.btn_in = 1'b1;
        exp_count  = 8'd1;
        exp_q.push_back('{1'b1, 16, 8'd1, 1'b1});
        $display("press   sampled edge 10 expect rise at 16 count 1");
        wait_edge(11);
        chk("press_busy_e11",  int'(bus.busy), 0);
        wait_edge(12);
        chk("press_busy_e12",  int'(bus.busy), 1);
        wait_edge(15);
        chk("press_busy_e15",  int'(bus.busy), 1);
        chk("press_level_e15", int'(bus.btn_level), 0);
        wait_edge(16);
        chk("press_busy_e16",  int'(bus.busy), 0);
        chk("press_level_e16", int'(bus.btn_level), 1);
        wait_edge(17);
        chk("press_rise_e17",  int'(bus.rise_pulse), 0);

        // Release sampled at edge 40 -> fall at edge 46.
        wait_edge(39);
        bus.btn_in = 1'b0;
        exp_q.push_back('{1'b0, 46, 8'd1, 1'b0});
        $display("release sampled edge 40 expect fall at 46 count 1");
        wait_edge(47);
        chk("rel_fall_e47",  int'(bus.fall_pulse),  0);
        chk("rel_level_e47", int'(bus.btn_level),   0);
        chk("rel_count_e47", int'(bus.press_count), 1);

        // Bounce: high for 3 sampled edges (51..53), then low.
        wait_edge(50);
        bus.btn_in = 1'b1;
        wait_edge(53);
        bus.btn_in = 1'b0;
        wait_edge(55);
        chk("bounce_busy_e55", int'(bus.busy), 1);
        wait_edge(57);
        chk("bounce_busy_e57", int'(bus.busy), 0);
        chk("bounce_level",    int'(bus.btn_level), 0);
        chk("bounce_count",    int'(bus.press_count), 1);
        $display("bounce  done at edge %0d", cyc);

        // Clear, then 256 presses to exercise the wrap.
        bus.cnt_clr = 1'b1;
        wait_edge(cyc + 1);
        bus.cnt_clr = 1'b0;
        exp_count   = 8'd0;
        chk("clr_count", int'(bus.press_count), 0);
        for (int i = 0; i < 256; i++) begin
            do_press(1'b0);
            if (i == 254) chk("wrap_255", int'(bus.press_count), 255);
            if (i == 255) chk("wrap_0",   int'(bus.press_count), 0);
            do_release();
        end

        // One press (count 1), then clear coinciding with a rise -> 1, not 2.
        do_press(1'b0);
        do_release();
        do_press(1'b1);
        chk("clr_with_rise", int'(bus.press_count), 1);
        do_release();

        // Reset mid-qualification with stab_cnt=2.
        bus.btn_in = 1'b1;
        k = cyc + 1;
        wait_edge(k + 4);
        chk("midrst_busy_before", int'(bus.busy), 1);
        reset = 1'b0;
        #1;
        chk("midrst_busy",  int'(bus.busy),        0);
        chk("midrst_level", int'(bus.btn_level),   0);
        chk("midrst_rise",  int'(bus.rise_pulse),  0);
        chk("midrst_count", int'(bus.press_count), 0);
        $display("reset   asserted mid-check at edge %0d", cyc);
        exp_count = 8'd0;
        wait_edge(cyc + 2);
        reset = 1'b1;
        k = cyc + 1;
        exp_count = 8'd1;
        exp_q.push_back('{1'b1, k + LAT, 8'd1, 1'b1});
        $display("press   held through reset, sampled edge %0d expect rise at %0d", k, k + LAT);
        wait_edge(k + LAT + 2);
        chk("postrst_level", int'(bus.btn_level), 1);
        do_release();

        // cnt_clr alone.
        bus.cnt_clr = 1'b1;
        wait_edge(cyc + 1);
        bus.cnt_clr = 1'b0;
        exp_count   = 8'd0;
        chk("clr_alone", int'(bus.press_count), 0);

        wait_edge(cyc + 10);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
